// File: rtl/inst_enc_pkg.sv
// rtl/inst_enc_pkg.sv - shared RV32I opcode constants, format/state enums and encoder helpers
package inst_enc_pkg;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_FENCE  = 7'h0F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  localparam int FIFO_DEPTH = 2;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_ILLEGAL
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } enc_state_e;

  // Encoding format selected by the major opcode.
  function automatic fmt_e opcode_fmt(input logic [6:0] op);
    fmt_e f;
    case (op)
      OP_LUI, OP_AUIPC:                             f = FMT_U;
      OP_JAL:                                       f = FMT_J;
      OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM: f = FMT_I;
      OP_BRANCH:                                    f = FMT_B;
      OP_STORE:                                     f = FMT_S;
      OP_OP:                                        f = FMT_R;
      default:                                      f = FMT_ILLEGAL;
    endcase
    return f;
  endfunction

  // True when v is representable as a signed value of the given bit width:
  // everything above the sign bit must be a copy of it.
  function automatic logic fits_signed(input logic [31:0] v, input int bits);
    logic [31:0] hi;
    hi = 32'($signed(v) >>> (bits - 1));
    return (hi == 32'h0) || (hi == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/inst_pack.sv
// rtl/inst_pack.sv - combinational field/immediate packer; range check under INST_ENC_RANGE_CHECK_EN
module inst_pack
  import inst_enc_pkg::*;
(
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output fmt_e        o_fmt,
  output logic [31:0] o_inst,
  output logic        o_range_ok
);

  fmt_e w_fmt;

  assign w_fmt = opcode_fmt(i_opcode);
  assign o_fmt = w_fmt;

  // Scatter the fields into the standard RV32I bit positions for the format.
  always_comb begin
    o_inst = 32'h0;
    case (w_fmt)
      FMT_R: o_inst = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      FMT_I: o_inst = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
      FMT_S: o_inst = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
      FMT_B: o_inst = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                       i_imm[4:1], i_imm[11], i_opcode};
      FMT_U: o_inst = {i_imm[31:12], i_rd, i_opcode};
      FMT_J: o_inst = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
      default: o_inst = 32'h0;
    endcase
  end

  // Immediate must survive packing without losing information.
  always_comb begin
    o_range_ok = 1'b1;
`ifdef INST_ENC_RANGE_CHECK_EN
    case (w_fmt)
      FMT_I, FMT_S: o_range_ok = fits_signed(i_imm, 12);
      FMT_B:        o_range_ok = fits_signed(i_imm, 13) && !i_imm[0];
      FMT_J:        o_range_ok = fits_signed(i_imm, 21) && !i_imm[0];
      FMT_U:        o_range_ok = (i_imm[11:0] == 12'h0);
      default:      o_range_ok = 1'b1;
    endcase
`endif
  end

endmodule

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - streaming RV32I encoder top: FSM, PC counter, 2-entry output FIFO; optional INST_ENC_RANGE_CHECK_EN
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [PC_W-1:0] pc_base,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_last,
  input  logic [6:0]      opcode,
  input  logic [4:0]      rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [31:0]     imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [PC_W-1:0] out_pc,
  output logic            done,
  output logic            err_illegal
`ifdef INST_ENC_RANGE_CHECK_EN
  ,
  output logic            err_range
`endif
);

  enc_state_e      r_state;
  enc_state_e      w_state_nxt;

  logic [31:0]     r_fifo_inst [FIFO_DEPTH];
  logic [PC_W-1:0] r_fifo_pc   [FIFO_DEPTH];
  logic            r_wr_ptr;
  logic            r_rd_ptr;
  logic [1:0]      r_count;
  logic [PC_W-1:0] r_pc;

  fmt_e            w_fmt;
  logic [31:0]     w_inst;
  logic            w_range_ok;
  logic            w_fifo_full;
  logic            w_accept;
  logic            w_legal;
  logic            w_wr;
  logic            w_rd;

  inst_pack u_pack (
    .i_opcode   (opcode),
    .i_rd       (rd),
    .i_rs1      (rs1),
    .i_rs2      (rs2),
    .i_funct3   (funct3),
    .i_funct7   (funct7),
    .i_imm      (imm),
    .o_fmt      (w_fmt),
    .o_inst     (w_inst),
    .o_range_ok (w_range_ok)
  );

  assign w_fifo_full = (r_count == 2'd2);
  assign w_accept    = in_valid && in_ready;
  assign w_legal     = (w_fmt != FMT_ILLEGAL) && w_range_ok;
  assign w_wr        = w_accept && w_legal;
  assign w_rd        = out_valid && out_ready;

  assign out_valid = (r_count != 2'd0);
  assign out_inst  = out_valid ? r_fifo_inst[r_rd_ptr] : 32'h0;
  assign out_pc    = out_valid ? r_fifo_pc[r_rd_ptr] : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus the state-derived handshake and done pulse.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        in_ready = !w_fifo_full;
        if (in_valid && !w_fifo_full && in_last) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_count == 2'd0) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output FIFO: registered entries give the one-cycle latency and keep the
  // head stable while the sink stalls. Reset discards any queued words.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_inst[i] <= 32'h0;
        r_fifo_pc[i]   <= '0;
      end
    end else begin
      if (w_wr) begin
        r_fifo_inst[r_wr_ptr] <= w_inst;
        r_fifo_pc[r_wr_ptr]   <= r_pc;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_rd) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // PC counter advances only for words that actually enter the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_pc <= pc_base;
    end else if (w_wr) begin
      r_pc <= r_pc + PC_W'(3'd4);
    end
  end

  // Sticky drop flags, cleared when a new program starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_illegal <= 1'b0;
    end else if (r_state == ST_IDLE && start) begin
      err_illegal <= 1'b0;
    end else if (w_accept && w_fmt == FMT_ILLEGAL) begin
      err_illegal <= 1'b1;
    end
  end

`ifdef INST_ENC_RANGE_CHECK_EN
  // Range flag only exists when immediates are checked.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_range <= 1'b0;
    end else if (r_state == ST_IDLE && start) begin
      err_range <= 1'b0;
    end else if (w_accept && w_fmt != FMT_ILLEGAL && !w_range_ok) begin
      err_range <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - self-checking bench for inst_encoder; follows INST_ENC_RANGE_CHECK_EN
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] pc_base = 32'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [6:0]  opcode = 7'h0;
  logic [4:0]  rd = 5'h0;
  logic [4:0]  rs1 = 5'h0;
  logic [4:0]  rs2 = 5'h0;
  logic [2:0]  funct3 = 3'h0;
  logic [6:0]  funct7 = 7'h0;
  logic [31:0] imm = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        done;
  logic        err_illegal;
`ifdef INST_ENC_RANGE_CHECK_EN
  logic        err_range;
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  inst_encoder #(.PC_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pc_base     (pc_base),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_last     (in_last),
    .opcode      (opcode),
    .rd          (rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .funct3      (funct3),
    .funct7      (funct7),
    .imm         (imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .done        (done),
    .err_illegal (err_illegal)
`ifdef INST_ENC_RANGE_CHECK_EN
    ,
    .err_range   (err_range)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_out = 0;
  logic [31:0] m_pc = 32'h0;
  bit          m_err_ill = 1'b0;
  bit          m_err_rng = 1'b0;
  bit          rnd_ready = 1'b0;
  vec_t        tbl[7];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: format class from the opcode list, -1 for illegal.
  function automatic int ref_fmt(input logic [6:0] op);
    case (op)
      7'h33:                             return 0;
      7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: return 1;
      7'h23:                             return 2;
      7'h63:                             return 3;
      7'h37, 7'h17:                      return 4;
      7'h6F:                             return 5;
      default:                           return -1;
    endcase
  endfunction

  function automatic bit ref_range_ok(input int f, input logic [31:0] v);
    int s;
    s = signed'(v);
    case (f)
      1, 2:    return (s >= -2048) && (s <= 2047);
      3:       return (s >= -4096) && (s <= 4095) && (s % 2 == 0);
      5:       return (s >= -1048576) && (s <= 1048575) && (s % 2 == 0);
      4:       return (v % 4096) == 0;
      default: return 1'b1;
    endcase
  endfunction

  // Reference encoding built from shifts and masks of the architectural fields.
  function automatic logic [31:0] ref_encode(input logic [6:0] op, input logic [4:0] d,
      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] v);
    logic [31:0] o, dd, a, b, c, g, h;
    o = 32'(op); dd = 32'(d) << 7; a = 32'(f3) << 12; b = 32'(s1) << 15;
    c = 32'(s2) << 20; g = 32'(f7) << 25; h = 32'h0;
    case (ref_fmt(op))
      0: h = o | dd | a | b | c | g;
      1: h = o | dd | a | b | ((v & 32'hFFF) << 20);
      2: h = o | a | b | c | (((v >> 5) & 32'h7F) << 25) | ((v & 32'h1F) << 7);
      3: h = o | a | b | c | (((v >> 12) & 32'h1) << 31) | (((v >> 5) & 32'h3F) << 25)
             | (((v >> 1) & 32'hF) << 8) | (((v >> 11) & 32'h1) << 7);
      4: h = o | dd | (v & 32'hFFFF_F000);
      5: h = o | dd | (((v >> 20) & 32'h1) << 31) | (((v >> 1) & 32'h3FF) << 21)
             | (((v >> 11) & 32'h1) << 20) | (((v >> 12) & 32'hFF) << 12);
      default: h = 32'h0;
    endcase
    return h;
  endfunction

  // Output monitor: every visible word must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_output: got %h at pc %h expected none", out_inst, out_pc);
        end else begin
          check32("out_inst", out_inst, sb_q[0].inst);
          check32("out_pc", out_pc, sb_q[0].pc);
          if (out_ready) begin
            void'(sb_q.pop_front());
            n_out++;
          end
        end
      end
    end
  end

  // Random sink backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // All tasks below are entered at posedge+1 and return at posedge+1.
  task automatic begin_prog(input logic [31:0] base);
    start = 1'b1;
    pc_base = base;
    @(posedge clk); #1;
    start = 1'b0;
    m_pc = base;
    m_err_ill = 1'b0;
    m_err_rng = 1'b0;
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
      input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] v, input bit last, input logic [31:0] exp_inst, input bit use_exp,
      output int waited);
    int f;
    opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = v;
    in_last = last;
    in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 40 cycles");
    end else begin
      f = ref_fmt(op);
      if (f < 0) m_err_ill = 1'b1;
      else if (RANGE_EN && !ref_range_ok(f, v)) m_err_rng = 1'b1;
      else begin
        sb_q.push_back('{use_exp ? exp_inst : ref_encode(op, d, s1, s2, f3, f7, v), m_pc});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_done();
    int cyc;
    bit seen;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      cyc++;
    end
    check32("done_pulse", 32'(seen), 32'd1);
    if (seen) begin
      @(negedge clk);
      check32("done_one_cycle", 32'(done), 32'd0);
    end
    check32("drained", 32'(sb_q.size()), 32'd0);
    check32("err_illegal", 32'(err_illegal), 32'(m_err_ill));
`ifdef INST_ENC_RANGE_CHECK_EN
    check32("err_range", 32'(err_range), 32'(m_err_rng));
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    int w;
    int n0;
    logic [6:0] ops[13];
    tbl[0] = '{7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,          32'h0020A423};
    tbl[1] = '{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC,  32'hFE000EE3};
    tbl[2] = '{7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,       32'h001000EF};
    tbl[3] = '{7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000,  32'h123452B7};
    tbl[4] = '{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0,          32'h002081B3};
    tbl[5] = '{7'h33, 5'd5, 5'd6, 5'd7, 3'd0, 7'h20, 32'h0,         32'h407302B3};
    tbl[6] = '{7'h17, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000,  32'h00001097};
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73,
            7'h7F, 7'h00};

    // Reset state.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check32("rst_out_valid", 32'(out_valid), 32'd0);
    check32("rst_out_inst", out_inst, 32'h0);
    check32("rst_out_pc", out_pc, 32'h0);
    check32("rst_in_ready", 32'(in_ready), 32'd0);
    check32("rst_done", 32'(done), 32'd0);
    check32("rst_err_illegal", 32'(err_illegal), 32'd0);
`ifdef INST_ENC_RANGE_CHECK_EN
    check32("rst_err_range", 32'(err_range), 32'd0);
`endif
    @(posedge clk); #1;

    // Single I-format instruction from pc 0x100.
    begin_prog(32'h100);
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h00500093, 1'b1, w);
    wait_done();

    // Table-driven mixed stream at full throughput.
    begin_prog(32'h0);
    for (int i = 0; i < 7; i++) begin
      send(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].f3, tbl[i].f7, tbl[i].imm,
           i == 6, tbl[i].exp, 1'b1, w);
      check32("throughput_wait", 32'(w), 32'd0);
    end
    wait_done();

    // Backpressure: two accepts fill the FIFO, in_ready drops, nothing lost.
    n0 = n_out;
    out_ready = 1'b0;
    begin_prog(32'h0);
    send(tbl[0].op, tbl[0].rd, tbl[0].rs1, tbl[0].rs2, tbl[0].f3, tbl[0].f7, tbl[0].imm,
         1'b0, tbl[0].exp, 1'b1, w);
    send(tbl[1].op, tbl[1].rd, tbl[1].rs1, tbl[1].rs2, tbl[1].f3, tbl[1].f7, tbl[1].imm,
         1'b0, tbl[1].exp, 1'b1, w);
    opcode = 7'h13; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check32("full_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(tbl[2].op, tbl[2].rd, tbl[2].rs1, tbl[2].rs2, tbl[2].f3, tbl[2].f7, tbl[2].imm,
         1'b0, tbl[2].exp, 1'b1, w);
    send(tbl[3].op, tbl[3].rd, tbl[3].rs1, tbl[3].rs2, tbl[3].f3, tbl[3].f7, tbl[3].imm,
         1'b1, tbl[3].exp, 1'b1, w);
    wait_done();
    check32("bp_out_count", 32'(n_out - n0), 32'd4);

    // Illegal opcode between two legal bundles.
    n0 = n_out;
    begin_prog(32'h0);
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 32'h00500093, 1'b1, w);
    send(7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 1'b0, 32'h0, 1'b0, w);
    send(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h00500113, 1'b1, w);
    wait_done();
    check32("ill_err_flag", 32'(err_illegal), 32'd1);
    check32("ill_out_count", 32'(n_out - n0), 32'd2);
    begin_prog(32'h200);
    @(negedge clk);
    check32("ill_flag_cleared", 32'(err_illegal), 32'd0);
    @(posedge clk); #1;
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b1, 32'h00100093, 1'b1, w);
    wait_done();

    // Immediate out of range for I-format.
    n0 = n_out;
    begin_prog(32'h0);
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, 1'b1, 32'h0, 1'b0, w);
    wait_done();
`ifdef INST_ENC_RANGE_CHECK_EN
    check32("range_err_flag", 32'(err_range), 32'd1);
    check32("range_out_count", 32'(n_out - n0), 32'd0);
`else
    check32("range_out_count", 32'(n_out - n0), 32'd1);
`endif

    // Reset with two words queued.
    out_ready = 1'b0;
    begin_prog(32'h0);
    send(tbl[4].op, tbl[4].rd, tbl[4].rs1, tbl[4].rs2, tbl[4].f3, tbl[4].f7, tbl[4].imm,
         1'b0, tbl[4].exp, 1'b1, w);
    send(tbl[5].op, tbl[5].rd, tbl[5].rs1, tbl[5].rs2, tbl[5].f3, tbl[5].f7, tbl[5].imm,
         1'b0, tbl[5].exp, 1'b1, w);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check32("rst_mid_out_valid", 32'(out_valid), 32'd0);
      check32("rst_mid_idle", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;

    // start while running is ignored: pc_base stays at the first value.
    begin_prog(32'h40);
    start = 1'b1; pc_base = 32'h80;
    @(posedge clk); #1;
    start = 1'b0;
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h00500093, 1'b1, w);
    wait_done();

    // Random programs with random backpressure, including PC wrap.
    rnd_ready = 1'b1;
    for (int p = 0; p < 6; p++) begin
      begin_prog(p == 0 ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC));
      for (int k = 0; k < 15; k++) begin
        logic [31:0] v;
        case ($urandom_range(0, 2))
          0:       v = $urandom;
          1:       v = 32'($urandom_range(0, 8191)) - 32'd4096;
          default: v = (32'($urandom_range(0, 4194303)) - 32'd2097152) & 32'hFFFF_FFFE;
        endcase
        send(ops[$urandom_range(0, 12)], 5'($urandom), 5'($urandom), 5'($urandom),
             3'($urandom), 7'($urandom), v, k == 14, 32'h0, 1'b0, w);
      end
      wait_done();
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
